// File: rtl/sync_counter_pkg.sv
// Shared types and helpers for the tclk-domain snapshot counter array.
package sync_counter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_LOW = 2'd2
  } snap_state_t;

  // Internal counters carry the prescale bits below the reported field.
  function automatic int cnt_width(input int counter_bits, input int offset_bits);
    return counter_bits + offset_bits;
  endfunction

endpackage

// File: rtl/sync_counter_chan.sv
// One enable counter with its live sticky-overflow bit.
module sync_counter_chan #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             tclk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             reload,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge tclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (reload) begin
      // Restart so the enabled capture cycle lands in the next interval.
      cnt <= CNT_W'(enable);
      ovf <= 1'b0;
    end else if (enable) begin
      if (&cnt) begin
        cnt <= SATURATE ? cnt : '0;
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sync_counter_array.sv
// N-channel enable counters with an atomic req/done snapshot of all channels.
module sync_counter_array
  import sync_counter_pkg::*;
#(
  parameter int NUM_CHAN      = 4,
  parameter int COUNTER_BITS  = 32,
  parameter int OFFSET_BITS   = 0,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_SNAP = 0
) (
  input  logic                             tclk,
  input  logic                             reset_n,
  input  logic [NUM_CHAN-1:0]              enable,
  input  logic                             clear,
  input  logic                             snap_req,
  output logic                             snap_done,
  output logic                             snap_busy,
  output logic [NUM_CHAN*COUNTER_BITS-1:0] counts,
  output logic [NUM_CHAN-1:0]              overflow,
  output logic [1:0]                       snap_state
);

  localparam int CNT_W = cnt_width(COUNTER_BITS, OFFSET_BITS);

  // Handshake: a snap_req 0->1 edge seen in IDLE starts one capture; snap_busy
  // stays high until snap_req has been observed low, and snap_done pulses once
  // the cycle after the capture.
  snap_state_t          state, state_next;
  logic                 req_prev;
  logic                 snap_rise;
  logic                 reload;
  logic [CNT_W-1:0]     cnt [NUM_CHAN];
  logic [NUM_CHAN-1:0]  ovf_live;

  assign snap_rise  = snap_req & ~req_prev;
  assign reload     = (CLEAR_ON_SNAP != 0) && (state == CAPTURE);
  assign snap_busy  = (state != IDLE);
  assign snap_state = state;

  always_ff @(posedge tclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      req_prev <= 1'b0;
    end else begin
      state    <= state_next;
      req_prev <= snap_req;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (snap_rise) state_next = CAPTURE;
      CAPTURE:  state_next = WAIT_LOW;
      WAIT_LOW: if (!snap_req) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge tclk or negedge reset_n) begin
    if (!reset_n) begin
      counts    <= '0;
      overflow  <= '0;
      snap_done <= 1'b0;
    end else begin
      snap_done <= (state == CAPTURE);
      if (state == CAPTURE) begin
        for (int i = 0; i < NUM_CHAN; i++) begin
          counts[i*COUNTER_BITS +: COUNTER_BITS] <= cnt[i][CNT_W-1:OFFSET_BITS];
        end
        overflow <= ovf_live;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    sync_counter_chan #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE != 0)
    ) u_chan (
      .tclk    (tclk),
      .reset_n (reset_n),
      .enable  (enable[g]),
      .clear   (clear),
      .reload  (reload),
      .cnt     (cnt[g]),
      .ovf     (ovf_live[g])
    );
  end

endmodule

// File: tb/tb_sync_counter_array.sv
// Directed bench for sync_counter_array across several parameterisations.
module tb_sync_counter_array;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Group A: 4 channels, 32-bit, wrap, no clear-on-snap.
  logic         rst_a, clear_a, snap_a, done_a, busy_a;
  logic [3:0]   enable_a, overflow_a;
  logic [127:0] counts_a;
  logic [1:0]   state_a;

  // Group S: single-channel variants sharing one stimulus.
  logic         rst_s, clear_s, snap_s;
  logic [0:0]   enable_s;
  logic         done_b, done_c, done_d, done_e, busy_b, busy_c, busy_d, busy_e;
  logic [0:0]   ovf_b, ovf_c, ovf_d, ovf_e;
  logic [1:0]   state_b, state_c, state_d, state_e;
  logic [7:0]   counts_b;
  logic [3:0]   counts_c, counts_d;
  logic [15:0]  counts_e;

  sync_counter_array #(.NUM_CHAN(4)) dut_a (
    .tclk(clk), .reset_n(rst_a), .enable(enable_a), .clear(clear_a), .snap_req(snap_a),
    .snap_done(done_a), .snap_busy(busy_a), .counts(counts_a), .overflow(overflow_a),
    .snap_state(state_a));

  sync_counter_array #(.NUM_CHAN(1), .COUNTER_BITS(8), .OFFSET_BITS(4)) dut_b (
    .tclk(clk), .reset_n(rst_s), .enable(enable_s), .clear(clear_s), .snap_req(snap_s),
    .snap_done(done_b), .snap_busy(busy_b), .counts(counts_b), .overflow(ovf_b),
    .snap_state(state_b));

  sync_counter_array #(.NUM_CHAN(1), .COUNTER_BITS(4)) dut_c (
    .tclk(clk), .reset_n(rst_s), .enable(enable_s), .clear(clear_s), .snap_req(snap_s),
    .snap_done(done_c), .snap_busy(busy_c), .counts(counts_c), .overflow(ovf_c),
    .snap_state(state_c));

  sync_counter_array #(.NUM_CHAN(1), .COUNTER_BITS(4), .SATURATE(1)) dut_d (
    .tclk(clk), .reset_n(rst_s), .enable(enable_s), .clear(clear_s), .snap_req(snap_s),
    .snap_done(done_d), .snap_busy(busy_d), .counts(counts_d), .overflow(ovf_d),
    .snap_state(state_d));

  sync_counter_array #(.NUM_CHAN(1), .COUNTER_BITS(16), .CLEAR_ON_SNAP(1)) dut_e (
    .tclk(clk), .reset_n(rst_s), .enable(enable_s), .clear(clear_s), .snap_req(snap_s),
    .snap_done(done_e), .snap_busy(busy_e), .counts(counts_e), .overflow(ovf_e),
    .snap_state(state_e));

  typedef struct {
    int          n [4];
    int unsigned e [4];
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_a(input int i);
    return counts_a[i*32 +: 32];
  endfunction

  task automatic do_snap_a;
    @(negedge clk) snap_a = 1'b1;
    @(negedge clk);
    check("a_busy_capture", busy_a, 1);
    check("a_done_early", done_a, 0);
    @(negedge clk);
    check("a_done_pulse", done_a, 1);
    @(negedge clk);
    check("a_done_single", done_a, 0);
    snap_a = 1'b0;
    @(negedge clk);
    check("a_busy_release", busy_a, 0);
  endtask

  task automatic do_snap_s;
    @(negedge clk) snap_s = 1'b1;
    @(negedge clk);
    check("s_done_early", done_e, 0);
    @(negedge clk);
    check("s_done_pulse_b", done_b, 1);
    check("s_done_pulse_e", done_e, 1);
    @(negedge clk);
    snap_s = 1'b0;
    @(negedge clk);
    check("s_busy_release", busy_e, 0);
  endtask

  initial begin
    int maxn;
    int done_seen;

    vecs[0].n = '{10, 0, 5, 17}; vecs[0].e = '{10, 0, 5, 17};
    vecs[1].n = '{1, 2, 3, 0};   vecs[1].e = '{11, 2, 8, 17};
    vecs[2].n = '{0, 0, 0, 0};   vecs[2].e = '{11, 2, 8, 17};
    vecs[3].n = '{4, 4, 4, 4};   vecs[3].e = '{15, 6, 12, 21};

    rst_a = 1'b0; clear_a = 1'b0; snap_a = 1'b0; enable_a = '0;
    rst_s = 1'b0; clear_s = 1'b0; snap_s = 1'b0; enable_s = '0;
    repeat (2) @(negedge clk);
    check("a_reset_counts", counts_a[63:0], 0);
    check("a_reset_ovf", overflow_a, 0);
    check("a_reset_done", done_a, 0);
    check("a_reset_busy", busy_a, 0);
    check("a_reset_state", state_a, 0);
    check("s_reset_counts", {counts_b, counts_c, counts_d, counts_e}, 0);
    rst_a = 1'b1;
    rst_s = 1'b1;

    // Table-driven accumulation on group A.
    for (int r = 0; r < 4; r++) begin
      maxn = 0;
      for (int i = 0; i < 4; i++) if (vecs[r].n[i] > maxn) maxn = vecs[r].n[i];
      for (int c = 0; c < maxn; c++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) enable_a[i] = (c < vecs[r].n[i]);
      end
      @(negedge clk) enable_a = '0;
      do_snap_a();
      for (int i = 0; i < 4; i++) check($sformatf("a_vec%0d_ch%0d", r, i), cnt_a(i), vecs[r].e[i]);
      check($sformatf("a_vec%0d_ovf", r), overflow_a, 0);
    end

    // snap_req held high for 20 cycles while ch0 counts on.
    @(negedge clk);
    snap_a = 1'b1;
    enable_a = 4'b0001;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    enable_a = '0;
    snap_a = 1'b0;
    check("a_hold_one_done", done_seen, 1);
    check("a_hold_frozen_ch0", cnt_a(0), 16);
    check("a_hold_frozen_ch3", cnt_a(3), 21);
    @(negedge clk);
    check("a_hold_busy_release", busy_a, 0);
    do_snap_a();
    check("a_resnap_ch0", cnt_a(0), 35);
    check("a_resnap_ch1", cnt_a(1), 6);

    // Reset asserted during the CAPTURE cycle.
    @(negedge clk) snap_a = 1'b1;
    @(negedge clk);
    check("a_rst_in_capture", busy_a, 1);
    rst_a = 1'b0;
    #1;
    check("a_rst_counts", counts_a, 0);
    check("a_rst_ovf", overflow_a, 0);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_done", done_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    snap_a = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    check("a_rst_no_done", done_seen, 0);

    // clear coinciding with the capture cycle.
    for (int c = 0; c < 5; c++) @(negedge clk) enable_a = 4'b0100;
    @(negedge clk) enable_a = '0;
    @(negedge clk) snap_a = 1'b1;
    @(negedge clk) clear_a = 1'b1;
    @(negedge clk) clear_a = 1'b0;
    check("a_clrcap_done", done_a, 1);
    check("a_clrcap_preclear", cnt_a(2), 5);
    @(negedge clk) snap_a = 1'b0;
    @(negedge clk);
    do_snap_a();
    check("a_clrcap_zeroed", cnt_a(2), 0);

    // Group S: 100 enabled cycles through prescale, wrap, saturate, clear-on-snap.
    for (int c = 0; c < 100; c++) @(negedge clk) enable_s = 1'b1;
    @(negedge clk) enable_s = 1'b0;
    do_snap_s();
    check("b_prescale", counts_b, 6);
    check("b_ovf", ovf_b, 0);
    check("c_wrap", counts_c, 4);
    check("c_ovf", ovf_c, 1);
    check("d_sat", counts_d, 15);
    check("d_ovf", ovf_d, 1);
    check("e_count", counts_e, 100);
    check("e_ovf", ovf_e, 0);

    @(negedge clk) clear_s = 1'b1;
    @(negedge clk) clear_s = 1'b0;
    check("d_clear_keeps_counts", counts_d, 15);
    check("d_clear_keeps_ovf", ovf_d, 1);
    do_snap_s();
    check("b_after_clear", counts_b, 0);
    check("c_after_clear", {counts_c, ovf_c}, 0);
    check("d_after_clear", counts_d, 0);
    check("d_ovf_after_clear", ovf_d, 0);
    check("e_after_clear", counts_e, 0);

    // Clear-on-snap with continuous enable: captures 30 edges apart yield 30.
    @(negedge clk) enable_s = 1'b1;
    repeat (48) @(negedge clk);
    do_snap_s();
    check("e_cos_first", counts_e, 50);
    repeat (25) @(negedge clk);
    do_snap_s();
    check("e_cos_interval", counts_e, 30);
    check("e_cos_ovf", ovf_e, 0);
    @(negedge clk) enable_s = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
